// File: rtl/int_lpc_seq.sv
// int_lpc_seq: Int_LPC stage sequencer (one LSP interpolation pass, then two lsp_to_az passes).
// Defining INT_LPC_SEQ_WATCHDOG_EN adds a per-WAIT-state timeout that raises a sticky err and forces FIN.
module int_lpc_seq #(
  parameter logic [11:0] LSP_TEMP_ADDR  = 12'h0A0,
  parameter logic [11:0] LSP_NEW_ADDR   = 12'h0B0,
  parameter logic [11:0] A_T_LOW_ADDR   = 12'h0C0,
  parameter logic [11:0] A_T_HIGH_ADDR  = 12'h0D0,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        interp_start,
  input  logic        interp_done,
  output logic        lsp_az_start,
  input  logic        lsp_az_done,
  output logic [11:0] lsp_az_addr1,
  output logic [11:0] lsp_az_addr2,
  output logic [1:0]  mem_sel,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] INT_GO   = 3'd1;
  localparam logic [2:0] INT_WAIT = 3'd2;
  localparam logic [2:0] AZ1_GO   = 3'd3;
  localparam logic [2:0] AZ1_WAIT = 3'd4;
  localparam logic [2:0] AZ2_GO   = 3'd5;
  localparam logic [2:0] AZ2_WAIT = 3'd6;
  localparam logic [2:0] FIN      = 3'd7;

  localparam logic [1:0] SEL_EXT    = 2'd0;
  localparam logic [1:0] SEL_INTERP = 2'd1;
  localparam logic [1:0] SEL_AZ     = 2'd2;

  localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYCLES - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       in_wait;
  logic       wait_done;
  logic       wd_fire;

  function automatic logic [1:0] sel_for(input logic [2:0] s);
    logic [1:0] sel;
    sel = SEL_EXT;
    case (s)
      INT_GO, INT_WAIT:                 sel = SEL_INTERP;
      AZ1_GO, AZ1_WAIT, AZ2_GO, AZ2_WAIT: sel = SEL_AZ;
      default:                          sel = SEL_EXT;
    endcase
    return sel;
  endfunction

  assign in_wait   = (state == INT_WAIT) || (state == AZ1_WAIT) || (state == AZ2_WAIT);
  assign wait_done = (state == INT_WAIT) ? interp_done : lsp_az_done;

`ifdef INT_LPC_SEQ_WATCHDOG_EN
  logic [12:0] wd_cnt;
  logic        err_q;

  // Counter is zero in the first cycle of every WAIT state; GO/FIN/IDLE keep it cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (!in_wait) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 13'd1;
    end
  end

  assign wd_fire = in_wait && !wait_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err_q <= 1'b0;
    end else if (wd_fire) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic wd_unused;
  assign wd_unused = ^WD_LAST;
  assign wd_fire   = 1'b0;
  assign err       = 1'b0;
`endif

  // Engine done is only honoured in WAIT states, so a held or stale done never skips a pass.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = INT_GO;
      INT_GO:   state_nxt = INT_WAIT;
      INT_WAIT: begin
        if (interp_done)  state_nxt = AZ1_GO;
        else if (wd_fire) state_nxt = FIN;
      end
      AZ1_GO:   state_nxt = AZ1_WAIT;
      AZ1_WAIT: begin
        if (lsp_az_done)  state_nxt = AZ2_GO;
        else if (wd_fire) state_nxt = FIN;
      end
      AZ2_GO:   state_nxt = AZ2_WAIT;
      AZ2_WAIT: begin
        if (lsp_az_done || wd_fire) state_nxt = FIN;
      end
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      interp_start <= 1'b0;
      lsp_az_start <= 1'b0;
      mem_sel      <= SEL_EXT;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      done         <= (state_nxt == FIN);
      interp_start <= (state_nxt == INT_GO);
      lsp_az_start <= (state_nxt == AZ1_GO) || (state_nxt == AZ2_GO);
      mem_sel      <= sel_for(state_nxt);
      busy         <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lsp_az_addr1 <= LSP_TEMP_ADDR;
      lsp_az_addr2 <= A_T_LOW_ADDR;
    end else if (state_nxt == AZ1_GO) begin
      lsp_az_addr1 <= LSP_TEMP_ADDR;
      lsp_az_addr2 <= A_T_LOW_ADDR;
    end else if (state_nxt == AZ2_GO) begin
      lsp_az_addr1 <= LSP_NEW_ADDR;
      lsp_az_addr2 <= A_T_HIGH_ADDR;
    end
  end

endmodule

// File: tb/tb_int_lpc_seq.sv
// Scoreboard bench for int_lpc_seq with behavioural interpolation and lsp_to_az engine models.
module tb_int_lpc_seq;

  localparam int I_T  = 5;
  localparam int HOLD = 3;
`ifdef INT_LPC_SEQ_WATCHDOG_EN
  localparam int TB_TIMEOUT = 16;
  localparam int AZ_T       = 10;
`else
  localparam int TB_TIMEOUT = 4096;
  localparam int AZ_T       = 20;
`endif
  localparam int LAT      = 4 + I_T + 2 * AZ_T;
  localparam int LAT_STALE = 5 + 2 * AZ_T;

  localparam int K_INTERP = 1;
  localparam int K_AZ     = 2;
  localparam int K_DONE   = 3;

  typedef struct {
    int          kind;
    logic [11:0] a1;
    logic [11:0] a2;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic        interp_start;
  logic        interp_done;
  logic        lsp_az_start;
  logic        lsp_az_done;
  logic [11:0] lsp_az_addr1;
  logic [11:0] lsp_az_addr2;
  logic [1:0]  mem_sel;
  logic        busy;
  logic        err;

  logic interp_force = 1'b0;
  logic interp_mute  = 1'b0;
  int   i_cnt  = 0;
  int   az_cnt = 0;
  int   cyc    = 0;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   n_interp = 0;
  int   n_az     = 0;
  int   n_done   = 0;
  int   interp_cyc = -1;
  int   done_log[$];
  int   az_log[$];
  logic [1:0] ms_log[$];
  logic [1:0] last_ms = 2'd0;

  int_lpc_seq #(
    .LSP_TEMP_ADDR (12'h0A0),
    .LSP_NEW_ADDR  (12'h0B0),
    .A_T_LOW_ADDR  (12'h0C0),
    .A_T_HIGH_ADDR (12'h0D0),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .interp_start(interp_start),
    .interp_done (interp_done),
    .lsp_az_start(lsp_az_start),
    .lsp_az_done (lsp_az_done),
    .lsp_az_addr1(lsp_az_addr1),
    .lsp_az_addr2(lsp_az_addr2),
    .mem_sel     (mem_sel),
    .busy        (busy),
    .err         (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Engine models: done rises T cycles after the start pulse, holds HOLD cycles, drops on a new start.
  always @(posedge clock) begin
    if (!reset)                  i_cnt <= 0;
    else if (interp_start)       i_cnt <= 1;
    else if (i_cnt != 0)         i_cnt <= (i_cnt == I_T + HOLD - 1) ? 0 : i_cnt + 1;
  end
  assign interp_done = interp_force | (!interp_mute && (i_cnt >= I_T));

  always @(posedge clock) begin
    if (!reset)                  az_cnt <= 0;
    else if (lsp_az_start)       az_cnt <= 1;
    else if (az_cnt != 0)        az_cnt <= (az_cnt == AZ_T + HOLD - 1) ? 0 : az_cnt + 1;
  end
  assign lsp_az_done = (az_cnt >= AZ_T);

  // Scoreboard monitor: every pulse from the DUT pops and checks the next expected event.
  always @(negedge clock) begin
    if (!reset) begin
      last_ms = 2'd0;
    end else begin
      if (mem_sel !== last_ms) begin
        ms_log.push_back(mem_sel);
        last_ms = mem_sel;
      end
      if (interp_start === 1'b1) begin
        n_interp++;
        interp_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_interp: got interp_start at cycle %0d, required no pulse", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.kind !== K_INTERP) begin
            failures++;
            $display("FAIL sb_interp: got event kind %0d at cycle %0d, required kind %0d", K_INTERP, cyc, mon_e.kind);
          end
        end
      end
      if (lsp_az_start === 1'b1) begin
        n_az++;
        az_log.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_az: got lsp_az_start at cycle %0d, required no pulse", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.kind !== K_AZ || lsp_az_addr1 !== mon_e.a1 || lsp_az_addr2 !== mon_e.a2) begin
            failures++;
            $display("FAIL sb_az: got kind %0d addr1 %h addr2 %h, required kind %0d addr1 %h addr2 %h",
                     K_AZ, lsp_az_addr1, lsp_az_addr2, mon_e.kind, mon_e.a1, mon_e.a2);
          end
        end
      end
      if (done === 1'b1) begin
        n_done++;
        done_log.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_done: got done at cycle %0d, required no pulse", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.kind !== K_DONE || err !== mon_e.err) begin
            failures++;
            $display("FAIL sb_done: got kind %0d err %b, required kind %0d err %b", K_DONE, err, mon_e.kind, mon_e.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push_run();
    exp_t e;
    e.kind = K_INTERP; e.a1 = 12'h000; e.a2 = 12'h000; e.err = 1'b0;
    sb.push_back(e);
    e.kind = K_AZ; e.a1 = 12'h0A0; e.a2 = 12'h0C0;
    sb.push_back(e);
    e.a1 = 12'h0B0; e.a2 = 12'h0D0;
    sb.push_back(e);
    e.kind = K_DONE; e.a1 = 12'h000; e.a2 = 12'h000;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    checks++; if (done !== 1'b0)         begin failures++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (interp_start !== 1'b0) begin failures++; $display("FAIL rst_interp_start: got %b, required 0", interp_start); end
    checks++; if (lsp_az_start !== 1'b0) begin failures++; $display("FAIL rst_az_start: got %b, required 0", lsp_az_start); end
    checks++; if (mem_sel !== 2'd0)      begin failures++; $display("FAIL rst_mem_sel: got %0d, required 0", mem_sel); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (err !== 1'b0)          begin failures++; $display("FAIL rst_err: got %b, required 0", err); end
    checks++; if (lsp_az_addr1 !== 12'h0A0) begin failures++; $display("FAIL rst_addr1: got %h, required 0a0", lsp_az_addr1); end
    checks++; if (lsp_az_addr2 !== 12'h0C0) begin failures++; $display("FAIL rst_addr2: got %h, required 0c0", lsp_az_addr2); end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_run();
    int s, i0, a0, d0, seq;
    push_run();
    ms_log.delete();
    i0 = n_interp; a0 = n_az; d0 = n_done;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    repeat (10) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 200 && n_done == d0; i++) tick();
    checks++;
    if (n_done != d0 + 1) begin
      failures++; $display("FAIL single_done: got %0d done pulses, required 1", n_done - d0);
    end else begin
      checks++;
      if (done_log[$] - s != LAT) begin
        failures++; $display("FAIL single_latency: got %0d cycles, required %0d", done_log[$] - s, LAT);
      end
    end
    seq = 0;
    foreach (ms_log[k]) seq = seq * 10 + int'(ms_log[k]);
    checks++; if (seq != 120) begin failures++; $display("FAIL single_mem_sel_seq: got 0,%0d required 0,120 (digits)", seq); end
    checks++; if (n_interp - i0 != 1) begin failures++; $display("FAIL single_interp_pulses: got %0d, required 1", n_interp - i0); end
    checks++; if (n_az - a0 != 2) begin failures++; $display("FAIL single_az_pulses: got %0d, required 2", n_az - a0); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy: got %b, required 0", busy); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL single_sb_left: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int s, i0, a0, d0;
    repeat (3) push_run();
    i0 = n_interp; a0 = n_az; d0 = n_done;
    start = 1'b1; s = cyc;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (n_done >= d0 + 3) break;
    end
    start = 1'b0;
    checks++;
    if (n_done != d0 + 3) begin
      failures++; $display("FAIL b2b_done: got %0d done pulses, required 3", n_done - d0);
    end else begin
      checks++;
      if (done_log[$-2] - s != LAT) begin
        failures++; $display("FAIL b2b_lat1: got %0d, required %0d", done_log[$-2] - s, LAT);
      end
      checks++;
      if (done_log[$-1] - done_log[$-2] != LAT + 1) begin
        failures++; $display("FAIL b2b_period2: got %0d, required %0d", done_log[$-1] - done_log[$-2], LAT + 1);
      end
      checks++;
      if (done_log[$] - done_log[$-1] != LAT + 1) begin
        failures++; $display("FAIL b2b_period3: got %0d, required %0d", done_log[$] - done_log[$-1], LAT + 1);
      end
    end
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy: got %b, required 0", busy); end
    checks++; if (n_interp - i0 != 3) begin failures++; $display("FAIL b2b_interp_pulses: got %0d, required 3", n_interp - i0); end
    checks++; if (n_az - a0 != 6) begin failures++; $display("FAIL b2b_az_pulses: got %0d, required 6", n_az - a0); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_sb_left: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int s, a0, d0;
    push_run();
    a0 = n_az;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 100 && n_az == a0; i++) tick();
    checks++;
    if (n_az != a0 + 1) begin
      failures++; $display("FAIL rmid_reach_az1: got %0d az pulses, required 1", n_az - a0);
    end
    repeat (3) tick();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    checks++; if (mem_sel !== 2'd0) begin failures++; $display("FAIL rmid_mem_sel: got %0d, required 0", mem_sel); end
    checks++; if (lsp_az_start !== 1'b0 || interp_start !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rmid_pulses: got az %b interp %b done %b, required 0 0 0", lsp_az_start, interp_start, done);
    end
    checks++; if (lsp_az_addr1 !== 12'h0A0 || lsp_az_addr2 !== 12'h0C0) begin
      failures++; $display("FAIL rmid_addr: got %h/%h, required 0a0/0c0", lsp_az_addr1, lsp_az_addr2);
    end
    sb.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    push_run();
    d0 = n_done;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    checks++; if (interp_cyc != s + 1) begin failures++; $display("FAIL rmid_restart: got interp pulse at cycle %0d, required %0d", interp_cyc, s + 1); end
    for (int i = 0; i < 200 && n_done == d0; i++) tick();
    checks++;
    if (n_done != d0 + 1) begin
      failures++; $display("FAIL rmid_done: got %0d done pulses, required 1", n_done - d0);
    end else begin
      checks++;
      if (done_log[$] - s != LAT) begin
        failures++; $display("FAIL rmid_latency: got %0d, required %0d", done_log[$] - s, LAT);
      end
    end
    tick();
  endtask

  task automatic test_stale_done();
    int s, d0;
    interp_force = 1'b1;
    repeat (2) tick();
    push_run();
    az_log.delete();
    d0 = n_done;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    for (int i = 0; i < 200 && n_done == d0; i++) tick();
    checks++;
    if (n_done != d0 + 1) begin
      failures++; $display("FAIL stale_done: got %0d done pulses, required 1", n_done - d0);
    end else begin
      checks++;
      if (done_log[$] - s != LAT_STALE) begin
        failures++; $display("FAIL stale_latency: got %0d, required %0d", done_log[$] - s, LAT_STALE);
      end
    end
    checks++;
    if (az_log.size() != 2) begin
      failures++; $display("FAIL stale_az_pulses: got %0d, required 2", az_log.size());
    end else begin
      checks++;
      if (az_log[0] - interp_cyc != 2) begin
        failures++; $display("FAIL stale_az1_gap: got %0d cycles after INT_GO, required 2", az_log[0] - interp_cyc);
      end
    end
    interp_force = 1'b0;
    tick();
  endtask

`ifdef INT_LPC_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    exp_t e;
    int s, d0;
    interp_mute = 1'b1;
    e.kind = K_INTERP; e.a1 = 12'h000; e.a2 = 12'h000; e.err = 1'b0;
    sb.push_back(e);
    e.kind = K_DONE; e.err = 1'b1;
    sb.push_back(e);
    d0 = n_done;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 100 && n_done == d0; i++) tick();
    checks++;
    if (n_done != d0 + 1) begin
      failures++; $display("FAIL wd_done: got %0d done pulses, required 1", n_done - d0);
    end else begin
      checks++;
      if (done_log[$] - interp_cyc != TB_TIMEOUT + 1) begin
        failures++; $display("FAIL wd_timing: got %0d cycles after INT_GO, required %0d", done_log[$] - interp_cyc, TB_TIMEOUT + 1);
      end
      checks++;
      if (err !== 1'b1 || done !== 1'b1) begin
        failures++; $display("FAIL wd_fin: got err %b done %b, required 1 1", err, done);
      end
    end
    tick();
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wd_sticky: got err %b busy %b, required 1 0", err, busy); end
    interp_mute = 1'b0;
    repeat (8) tick();
    push_run();
    d0 = n_done;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wd_clear: got err %b, required 0", err); end
    for (int i = 0; i < 200 && n_done == d0; i++) tick();
    checks++;
    if (n_done != d0 + 1 || done_log[$] - s != LAT) begin
      failures++; $display("FAIL wd_rerun: got %0d dones latency %0d, required 1 dones latency %0d", n_done - d0, done_log[$] - s, LAT);
    end
    tick();
  endtask
`else
  task automatic test_wait_forever();
    exp_t e;
    int d0, i0;
    interp_mute = 1'b1;
    e.kind = K_INTERP; e.a1 = 12'h000; e.a2 = 12'h000; e.err = 1'b0;
    sb.push_back(e);
    d0 = n_done; i0 = n_interp;
    start = 1'b1; tick(); start = 1'b0;
    repeat (300) tick();
    checks++; if (n_interp - i0 != 1) begin failures++; $display("FAIL hang_interp: got %0d pulses, required 1", n_interp - i0); end
    checks++; if (n_done != d0) begin failures++; $display("FAIL hang_done: got %0d done pulses, required 0", n_done - d0); end
    checks++; if (busy !== 1'b1 || mem_sel !== 2'd1) begin failures++; $display("FAIL hang_state: got busy %b mem_sel %0d, required 1 1", busy, mem_sel); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL hang_err: got %b, required 0", err); end
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    interp_mute = 1'b0;
    sb.delete();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_reset_mid();
    test_stale_done();
`ifdef INT_LPC_SEQ_WATCHDOG_EN
    test_watchdog();
`else
    test_wait_forever();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "time limit");
  end

endmodule
